// File: rtl/global_io.sv
`default_nettype none
// ============================================================================
//  Module   : global_io
//  Purpose  : Bit-serial shift-accumulate output stage of the DCIM macro.
//             Aligns the two 15-bit column partial sums (12- or 24-bit weight
//             mode) and folds the result into a 51-bit MSB-first accumulator.
//  Options  : GLOBAL_IO_SAT_EN - saturate at 2^51-1 instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module global_io (
  input  logic        clk,
  input  logic        rstn,      // asynchronous, active-high despite the name
  input  logic        st,
  input  logic        acm_en,
  input  logic        wwidth,
  input  logic [14:0] macout_a,
  input  logic [14:0] macout_b,
  output logic [50:0] nout
);

  localparam logic [50:0] C_ACC_MAX = {51{1'b1}};

  logic [50:0] w_add_out;
  logic [50:0] w_acc_next;
  logic [50:0] nout_d;
  logic [50:0] nout_q;

  // Weight alignment: the high half is ignored entirely in 12-bit mode.
  always_comb begin
    w_add_out = {36'd0, macout_a};
    if (wwidth) begin
      w_add_out = {36'd0, macout_a} + ({36'd0, macout_b} << 12);
    end
  end

`ifdef GLOBAL_IO_SAT_EN
  // Carry out of the 52-bit sum catches both a 1 shifted out of bit 50
  // and a sum overflow; a saturated value stays saturated on later shifts.
  logic [51:0] w_sum_wide;
  always_comb begin
    w_sum_wide = {nout_q, 1'b0} + {1'b0, w_add_out};
    w_acc_next = w_sum_wide[51] ? C_ACC_MAX : w_sum_wide[50:0];
  end
`else
  // Plain modulo-2^51 shift-accumulate; bit 50 falls off the top.
  always_comb begin
    w_acc_next = {nout_q[49:0], 1'b0} + w_add_out;
  end
`endif

  // Next-state selection: clear beats accumulate, otherwise hold.
  always_comb begin
    nout_d = nout_q;
    if (st) begin
      nout_d = '0;
    end else if (acm_en) begin
      nout_d = w_acc_next;
    end
  end

  // Accumulator register with asynchronous clear.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      nout_q <= '0;
    end else begin
      nout_q <= nout_d;
    end
  end

  assign nout = nout_q;

endmodule
`default_nettype wire

// File: tb/tb_global_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_global_io
//  Purpose  : Directed self-checking bench for global_io.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_global_io;

  logic        clk;
  logic        rstn;
  logic        st;
  logic        acm_en;
  logic        wwidth;
  logic [14:0] macout_a;
  logic [14:0] macout_b;
  logic [50:0] nout;

  int n_chk;
  int n_pass;

  global_io dut (
    .clk      (clk),
    .rstn     (rstn),
    .st       (st),
    .acm_en   (acm_en),
    .wwidth   (wwidth),
    .macout_a (macout_a),
    .macout_b (macout_b),
    .nout     (nout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [50:0] obs, input logic [50:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic step(input logic s, input logic en, input logic ww,
                      input logic [14:0] a, input logic [14:0] b);
    st = s; acm_en = en; wwidth = ww; macout_a = a; macout_b = b;
    @(posedge clk);
    #1;
  endtask

  // Reference: 64-bit integer arithmetic, then wrap or saturate.
  function automatic logic [50:0] ref_next(input logic [50:0] cur, input logic [50:0] add);
    longint unsigned s;
    longint unsigned lim;
    lim = (64'd1 << 51) - 64'd1;
    s = 64'(cur) * 64'd2 + 64'(add);
`ifdef GLOBAL_IO_SAT_EN
    if (s > lim) return lim[50:0];
    return s[50:0];
`else
    return s[50:0];
`endif
  endfunction

  logic [50:0] exp_v;
  logic [50:0] max_add;

  initial begin
    n_chk = 0; n_pass = 0;
    rstn = 1'b1; st = 1'b0; acm_en = 1'b1; wwidth = 1'b1;
    macout_a = 15'd1234; macout_b = 15'd4321;
    #1;
    chk("reset_async", nout, 51'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", nout, 51'd0);

    @(negedge clk);
    rstn = 1'b0;
    step(1'b1, 1'b1, 1'b0, 15'd77, 15'd0);
    chk("start_clear", nout, 51'd0);

    // 12-bit mode, macout_b must be ignored
    step(1'b0, 1'b1, 1'b0, 15'd10, 15'd999);  chk("w12_0", nout, 51'd10);
    step(1'b0, 1'b1, 1'b0, 15'd20, 15'd888);  chk("w12_1", nout, 51'd40);
    step(1'b0, 1'b1, 1'b0, 15'd30, 15'd777);  chk("w12_2", nout, 51'd110);

    // 24-bit mode
    step(1'b1, 1'b0, 1'b1, 15'd0, 15'd0);     chk("clr_24", nout, 51'd0);
    step(1'b0, 1'b1, 1'b1, 15'd10, 15'd1);    chk("w24_0", nout, 51'd4106);
    step(1'b0, 1'b1, 1'b1, 15'd20, 15'd2);    chk("w24_1", nout, 51'd16424);

    // Mode switch without clear: 4097 then 2*4097+3
    step(1'b1, 1'b0, 1'b0, 15'd0, 15'd0);
    step(1'b0, 1'b1, 1'b1, 15'd1, 15'd1);     chk("mix_w24", nout, 51'd4097);
    step(1'b0, 1'b1, 1'b0, 15'd3, 15'd5);     chk("mix_w12", nout, 51'd8197);

    // Enable gating
    step(1'b1, 1'b1, 1'b0, 15'd9, 15'd0);     chk("clr_wins", nout, 51'd0);
    step(1'b0, 1'b1, 1'b0, 15'd100, 15'd0);   chk("gate_0", nout, 51'd100);
    step(1'b0, 1'b0, 1'b0, 15'd50, 15'd3);    chk("gate_hold", nout, 51'd100);
    step(1'b0, 1'b0, 1'b1, 15'd7, 15'd7);     chk("gate_hold2", nout, 51'd100);
    step(1'b0, 1'b1, 1'b0, 15'd5, 15'd0);     chk("gate_1", nout, 51'd205);

    // Mid-run clear
    step(1'b0, 1'b1, 1'b0, 15'd1, 15'd0);     chk("run_0", nout, 51'd411);
    step(1'b0, 1'b1, 1'b0, 15'd2, 15'd0);     chk("run_1", nout, 51'd824);
    step(1'b1, 1'b1, 1'b1, 15'd500, 15'd500); chk("mid_clr", nout, 51'd0);
    step(1'b0, 1'b1, 1'b0, 15'd99, 15'd0);    chk("after_clr", nout, 51'd99);

    // Asynchronous reset mid-cycle, then release
    step(1'b0, 1'b1, 1'b0, 15'd1, 15'd0);     chk("pre_rst", nout, 51'd199);
    #2 rstn = 1'b1;
    #1 chk("async_rst", nout, 51'd0);
    @(negedge clk);
    rstn = 1'b0;
    step(1'b0, 1'b1, 1'b0, 15'd6, 15'd0);     chk("post_rst", nout, 51'd6);

    // Overflow: max inputs in 24-bit mode, add = 32767*4097 = 134246399
    max_add = 51'd134246399;
    step(1'b1, 1'b0, 1'b1, 15'd0, 15'd0);
    exp_v = '0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, 1'b1, 15'd32767, 15'd32767);
      exp_v = ref_next(exp_v, max_add);
      chk($sformatf("ovf_%0d", i), nout, exp_v);
    end
`ifdef GLOBAL_IO_SAT_EN
    chk("sat_pinned", nout, {51{1'b1}});
    step(1'b0, 1'b1, 1'b0, 15'd0, 15'd0);     chk("sat_stays", nout, {51{1'b1}});
`else
    // cycle 30 value in closed form: A*(2^30-1) mod 2^51
    begin
      longint unsigned v;
      v = 64'd134246399 * ((64'd1 << 30) - 64'd1);
      exp_v = v[50:0];
    end
    chk("wrap_value", nout, exp_v);
`endif
    step(1'b1, 1'b1, 1'b1, 15'd32767, 15'd32767);
    chk("ovf_clear", nout, 51'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
